simd_requant_sched: RTL and testbench

- Shares one requantization pipeline among NUM_REQ SIMD lane requesters.
- Pipeline stages: arithmetic right shift, round-half-up, saturate to WOUT.
- A round-robin arbiter grants one requester per cycle. Results return tagged with the requester ID over valid/ready.
- Sits between the SIMD accumulator lanes and the output write-back buffer.

---
 rtl/simd_requant_pkg.sv | 26 ++
 rtl/simd_requant_sched_arb.sv | 52 +++++
 rtl/simd_requant_sched.sv | 138 +++++++++++++
 tb/tb_simd_requant_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_requant_pkg.sv
// Shared constants and helpers for the SIMD requantization scheduler.
package simd_requant_pkg;

    typedef enum logic [0:0] {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    localparam rnd_mode_e RND_MODE = RND_HALF_UP;

    // ID width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest representable output value, zero-extended to 64 bits
    function automatic logic [63:0] sat_max(input int wout, input bit uns);
        return uns ? ((64'd1 << wout) - 64'd1) : ((64'd1 << (wout - 1)) - 64'd1);
    endfunction

    // Smallest representable output value, two's complement in 64 bits
    function automatic logic [63:0] sat_min(input int wout, input bit uns);
        return uns ? 64'd0 : ~((64'd1 << (wout - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/simd_requant_sched_arb.sv
// Round-robin arbiter: rotating-priority search from a pointer that
// moves one past the last granted requester.
module simd_rr_arbiter
    import simd_requant_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] ptr;
    logic           found;
    int unsigned    cand;

    // First valid requester at or after ptr; nothing granted while blocked or in reset
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
        if (!advance || rst) begin
            found     = 1'b0;
            grant_idx = '0;
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A grant is always a transfer (grant only goes to a valid requester)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/simd_requant_sched.sv
// Shared requantization pipeline (shift, round-half-up, saturate) for
// NUM_REQ SIMD lanes, results tagged with requester ID.
// Optional saturation counter: define SIMD_REQUANT_SAT_CNT_EN.
module simd_requant_sched
    import simd_requant_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIN          = 32,
    parameter int WOUT         = 16,
    parameter int SHW          = 5,
    parameter int UNSIGNED_OUT = 0,
    parameter int IDW          = clog2_min1(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIN-1:0] req_data,
    input  logic [NUM_REQ*SHW-1:0] req_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WOUT-1:0]        out_data,
    output logic [IDW-1:0]         out_id,
    output logic                   out_sat
`ifdef SIMD_REQUANT_SAT_CNT_EN
    ,
    input  logic                   sat_clr,
    output logic [15:0]            sat_count
`endif
);

    localparam logic [63:0] MAXV = sat_max(WOUT, UNSIGNED_OUT != 0);
    localparam logic [63:0] MINV = sat_min(WOUT, UNSIGNED_OUT != 0);

    logic                s2_load, arb_en;
    logic [NUM_REQ-1:0]  grant;
    logic [IDW-1:0]      grant_idx;
    logic signed [WIN-1:0] din;
    logic [SHW-1:0]      sh;
    logic signed [WIN:0] din_x, shifted, r_next;
    logic                rnd;
    logic                s1_valid;
    logic signed [WIN:0] s1_r;
    logic [IDW-1:0]      s1_id;
    logic [WOUT-1:0]     sat_data;
    logic                sat_flag;

    // S2 is the output register, so its valid is out_valid
    assign s2_load   = !out_valid || out_ready;
    assign arb_en    = !s1_valid || s2_load;
    assign req_ready = grant;

    simd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .clk       (clk),
        .rst       (reset),
        .req       (req_valid),
        .advance   (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select granted operand, shift arithmetically and add the round bit
    always_comb begin
        din     = req_data[grant_idx*WIN +: WIN];
        sh      = req_shift[grant_idx*SHW +: SHW];
        din_x   = {din[WIN-1], din};
        shifted = din_x >>> sh;
        rnd     = 1'b0;
        if (RND_MODE == RND_HALF_UP && sh != '0) begin
            rnd = din[sh - 1'b1];
        end
        r_next  = shifted + (WIN+1)'(rnd);
    end

    // S1: rounded value and ID register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_id    <= '0;
        end else if (arb_en) begin
            s1_valid <= |grant;
            if (|grant) begin
                s1_r  <= r_next;
                s1_id <= grant_idx;
            end
        end
    end

    // Clamp the S1 value into the output range
    always_comb begin
        sat_data = s1_r[WOUT-1:0];
        sat_flag = 1'b0;
        if (UNSIGNED_OUT != 0) begin
            if (s1_r[WIN]) begin
                sat_data = MINV[WOUT-1:0];
                sat_flag = 1'b1;
            end else if (s1_r[WIN-1:WOUT] != '0) begin
                sat_data = MAXV[WOUT-1:0];
                sat_flag = 1'b1;
            end
        end else if (!(s1_r[WIN:WOUT-1] == '0 || s1_r[WIN:WOUT-1] == '1)) begin
            sat_data = s1_r[WIN] ? MINV[WOUT-1:0] : MAXV[WOUT-1:0];
            sat_flag = 1'b1;
        end
    end

    // S2: output register, held while downstream stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_sat   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_data;
                out_id   <= s1_id;
                out_sat  <= sat_flag;
            end
        end
    end

`ifdef SIMD_REQUANT_SAT_CNT_EN
    // Count saturated results at handshake; clear has priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && sat_count != '1) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simd_requant_sched.sv
// Scoreboard bench for simd_requant_sched (default and unsigned-output instances).
module tb_simd_requant_sched;

    localparam int N = 4, WIN = 32, WOUT = 16, SHW = 5, IDW = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid, req_ready, req_ready_u;
    logic [N*WIN-1:0]   req_data;
    logic [N*SHW-1:0]   req_shift;
    logic               out_ready;
    logic               out_valid, out_sat, out_valid_u, out_sat_u;
    logic [WOUT-1:0]    out_data, out_data_u;
    logic [IDW-1:0]     out_id, out_id_u;
`ifdef SIMD_REQUANT_SAT_CNT_EN
    logic               sat_clr;
    logic [15:0]        sat_count, sat_count_u;
`endif

    always #5 clk = ~clk;

    simd_requant_sched #(.NUM_REQ(N), .WIN(WIN), .WOUT(WOUT), .SHW(SHW), .UNSIGNED_OUT(0)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_sat(out_sat)
`ifdef SIMD_REQUANT_SAT_CNT_EN
        , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
    );

    simd_requant_sched #(.NUM_REQ(N), .WIN(WIN), .WOUT(WOUT), .SHW(SHW), .UNSIGNED_OUT(1)) u_dutu (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_u),
        .req_data(req_data), .req_shift(req_shift), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_data(out_data_u), .out_id(out_id_u), .out_sat(out_sat_u)
`ifdef SIMD_REQUANT_SAT_CNT_EN
        , .sat_clr(sat_clr), .sat_count(sat_count_u)
`endif
    );

    int nvec = 0, nerr = 0;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [WOUT-1:0] d;
        logic            s;
    } exp_t;
    exp_t sbq[$];

    // Reference: returns {sat, data}
    function automatic logic [16:0] model(input logic [31:0] din, input logic [4:0] sh, input bit uns);
        longint v, q;
        v = longint'(signed'(din));
        q = v >>> sh;
        if (sh != 0) q += (v >>> (int'(sh) - 1)) & 64'sd1;
        if (uns) begin
            if (q < 0) return {1'b1, 16'h0000};
            if (q > 65535) return {1'b1, 16'hFFFF};
        end else begin
            if (q > 32767) return {1'b1, 16'h7FFF};
            if (q < -32768) return {1'b1, 16'h8000};
        end
        return {1'b0, q[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expected results for every request accepted at the coming edge
    task automatic push_accepts(output int n);
        logic [16:0] r;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                r = model(req_data[i*WIN +: WIN], req_shift[i*SHW +: SHW], 1'b0);
                sbq.push_back('{id: IDW'(i), d: r[15:0], s: r[16]});
                n++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
`ifdef SIMD_REQUANT_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        req_valid = 4'hF;
        #2;
        nvec++;
        if ({req_ready, out_valid, out_data, out_id, out_sat} !== '0) begin
            nerr++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h id=%0d s=%b, expected all zero",
                     req_ready, out_valid, out_data, out_id, out_sat);
        end
        @(posedge clk);
        req_valid = '0;
        #1 reset = 1'b0;
    endtask

    task automatic test_single(input string name, input logic [31:0] din, input logic [4:0] sh);
        logic [16:0] eu;
        int n;
        exp_t e;
        eu = model(din, sh, 1'b1);
        req_data[31:0] = din;
        req_shift[4:0] = sh;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        nvec++;
        if (req_ready !== 4'b0001) begin
            nerr++; $display("FAIL %s_grant: got %b, expected 0001", name, req_ready);
        end
        push_accepts(n);
        tick();
        req_valid = '0;
        #1;
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL %s_latency: out_valid=%b one cycle after accept, expected 0", name, out_valid);
        end
        tick();
        #1;
        nvec++;
        if (!(out_valid && out_ready) || sbq.size() == 0) begin
            nerr++; $display("FAIL %s_valid: out_valid=%b two cycles after accept, expected 1", name, out_valid);
        end else begin
            e = sbq.pop_front();
            if ({out_id, out_data, out_sat} !== {e.id, e.d, e.s}) begin
                nerr++;
                $display("FAIL %s_signed: got id=%0d d=%h s=%b, expected id=%0d d=%h s=%b",
                         name, out_id, out_data, out_sat, e.id, e.d, e.s);
            end
        end
        nvec++;
        if ({out_valid_u, out_data_u, out_sat_u} !== {1'b1, eu[15:0], eu[16]}) begin
            nerr++;
            $display("FAIL %s_unsigned: got v=%b d=%h s=%b, expected v=1 d=%h s=%b",
                     name, out_valid_u, out_data_u, out_sat_u, eu[15:0], eu[16]);
        end
        tick();
    endtask

    task automatic test_shift_round();
        test_single("rnd_12345", 32'h00012345, 5'd4);
        test_single("rnd_18", 32'h00000018, 5'd4);
        test_single("rnd_neg_half", 32'hFFFFFFF8, 5'd4);
        test_single("rnd_sh31", 32'h40000000, 5'd31);
    endtask

    task automatic test_saturation();
        test_single("sat_pos", 32'h00100000, 5'd0);
        test_single("sat_neg", 32'hFFF00000, 5'd0);
        test_single("sat_m1", 32'hFFFFFFFF, 5'd0);
        test_single("sat_edge", 32'h00007FFF, 5'd0);
    endtask

    task automatic test_fairness();
        logic [3:0] eg;
        int n;
        exp_t e;
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_data[i*WIN +: WIN] = $urandom_range(0, 32'h00FFFFFF) - 32'h00800000;
            req_shift[i*SHW +: SHW] = 5'($urandom_range(0, 12));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) begin
                eg = 4'b0001 << (k % 4);
                nvec++;
                if (req_ready !== eg) begin
                    nerr++; $display("FAIL fair_grant%0d: got %b, expected %b", k, req_ready, eg);
                end
            end
            if (k >= 2 && k < 10) begin
                nvec++;
                if (out_valid !== 1'b1) begin
                    nerr++; $display("FAIL fair_rate%0d: out_valid=%b, expected 1", k, out_valid);
                end
            end
            push_accepts(n);
            if (out_valid && out_ready) begin
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++; $display("FAIL fair_extra: got id=%0d d=%h, expected no output", out_id, out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({out_id, out_data, out_sat} !== {e.id, e.d, e.s}) begin
                        nerr++;
                        $display("FAIL fair_result: got id=%0d d=%h s=%b, expected id=%0d d=%h s=%b",
                                 out_id, out_data, out_sat, e.id, e.d, e.s);
                    end
                end
            end
            tick();
        end
        nvec++;
        if (sbq.size() != 0) begin
            nerr++; $display("FAIL fair_drain: %0d results missing, expected 0", sbq.size());
        end
    endtask

    task automatic test_backpressure();
        int n, acc;
        exp_t e;
        do_reset();
        acc = 0;
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            push_accepts(n);
            acc += n;
            if (out_valid) begin
                nvec++;
                if (sbq.size() == 0 || {out_id, out_data, out_sat} !== {sbq[0].id, sbq[0].d, sbq[0].s}) begin
                    nerr++;
                    $display("FAIL bp_hold%0d: got id=%0d d=%h s=%b, expected head of %0d queued results",
                             k, out_id, out_data, out_sat, sbq.size());
                end
            end
            tick();
        end
        nvec++;
        if (acc !== 2) begin
            nerr++; $display("FAIL bp_accepts: got %0d transfers, expected 2", acc);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 5) ? 4'hF : 4'h0;
            #1;
            push_accepts(n);
            if (out_valid && out_ready) begin
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++; $display("FAIL bp_extra: got id=%0d d=%h, expected no output", out_id, out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({out_id, out_data, out_sat} !== {e.id, e.d, e.s}) begin
                        nerr++;
                        $display("FAIL bp_result: got id=%0d d=%h s=%b, expected id=%0d d=%h s=%b",
                                 out_id, out_data, out_sat, e.id, e.d, e.s);
                    end
                end
            end
            tick();
        end
        nvec++;
        if (sbq.size() != 0) begin
            nerr++; $display("FAIL bp_drain: %0d results lost, expected 0", sbq.size());
        end
    endtask

    task automatic test_sparse_satcnt();
        int n;
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        req_data = '0;
        req_shift = '0;
        req_data[2*WIN +: WIN] = 32'h7FFFFFFF;
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 3) ? 4'b0100 : 4'b0000;
            #1;
            if (k < 3) begin
                nvec++;
                if (req_ready !== 4'b0100) begin
                    nerr++; $display("FAIL sparse_grant%0d: got %b, expected 0100", k, req_ready);
                end
            end
            push_accepts(n);
            if (out_valid && out_ready) begin
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++; $display("FAIL sparse_extra: got id=%0d d=%h, expected no output", out_id, out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({out_id, out_data, out_sat} !== {e.id, e.d, e.s}) begin
                        nerr++;
                        $display("FAIL sparse_result: got id=%0d d=%h s=%b, expected id=%0d d=%h s=%b",
                                 out_id, out_data, out_sat, e.id, e.d, e.s);
                    end
                end
            end
            tick();
        end
`ifdef SIMD_REQUANT_SAT_CNT_EN
        #1;
        nvec++;
        if (sat_count !== 16'd3) begin
            nerr++; $display("FAIL satcnt_three: got %0d, expected 3", sat_count);
        end
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        #1;
        nvec++;
        if (sat_count !== 16'd0) begin
            nerr++; $display("FAIL satcnt_clear: got %0d, expected 0", sat_count);
        end
        // a saturating handshake coinciding with clear must leave zero
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        #1;
        if (out_valid && out_sat) sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        #1;
        nvec++;
        if (sat_count !== 16'd0) begin
            nerr++; $display("FAIL satcnt_clr_wins: got %0d, expected 0", sat_count);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        exp_t e;
        do_reset();
        req_valid = 4'hF;
        tick();
        tick();
        #1;
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++; $display("FAIL mid_full: out_valid=%b, expected 1 before reset", out_valid);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if ({out_valid, req_ready, out_data, out_id, out_sat} !== '0) begin
            nerr++;
            $display("FAIL mid_async: got v=%b rdy=%b d=%h id=%0d s=%b, expected all zero",
                     out_valid, req_ready, out_data, out_id, out_sat);
        end
        sbq.delete();
        tick();
        req_valid = 4'b1010;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 2) req_valid = '0;
            #1;
            if (k == 0) begin
                nvec++;
                if ({req_ready, out_valid} !== {4'b0010, 1'b0}) begin
                    nerr++; $display("FAIL mid_first: got rdy=%b v=%b, expected rdy=0010 v=0", req_ready, out_valid);
                end
            end
            push_accepts(n);
            if (out_valid && out_ready) begin
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++; $display("FAIL mid_extra: got id=%0d d=%h, expected no output", out_id, out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({out_id, out_data, out_sat} !== {e.id, e.d, e.s}) begin
                        nerr++;
                        $display("FAIL mid_result: got id=%0d d=%h s=%b, expected id=%0d d=%h s=%b",
                                 out_id, out_data, out_sat, e.id, e.d, e.s);
                    end
                end
            end
            tick();
        end
        nvec++;
        if (sbq.size() != 0) begin
            nerr++; $display("FAIL mid_drain: %0d results missing, expected 0", sbq.size());
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_shift = '0;
        out_ready = 1'b0;
`ifdef SIMD_REQUANT_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        test_reset();
        test_shift_round();
        test_saturation();
        test_fairness();
        test_backpressure();
        test_sparse_satcnt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
